if_stage: RTL and testbench

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 212 +++++++++++++++++++++
 tb/tb_if_stage.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Brief    : Instruction fetch with one outstanding request, a one-entry
//            response buffer and the IF/ID register. Build option
//            IF_MISALIGN_CHK_EN traps misaligned redirect targets.
// Revision : 1.0
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic        misalign_exc
);

    localparam logic [31:0] c_nop       = 32'h0000_0013;
    localparam logic [31:0] c_word_mask = 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_KILL = 2'd2,
        ST_EXC  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] r_launch_pc;
    logic [31:0] w_launch_nxt;
    logic        r_pending;
    logic        w_pending_nxt;

    logic        r_buf_valid;
    logic        w_buf_valid_nxt;
    logic [31:0] r_buf_inst;
    logic [31:0] w_buf_inst_nxt;
    logic [31:0] r_buf_pc;
    logic [31:0] w_buf_pc_nxt;

    logic        r_id_valid;
    logic        w_id_valid_nxt;
    logic [31:0] r_id_inst;
    logic [31:0] w_id_inst_nxt;
    logic [31:0] r_id_pc;
    logic [31:0] w_id_pc_nxt;

    logic        w_accept;
    logic        w_resp_valid;
    logic [31:0] w_redirect_target;

`ifdef IF_MISALIGN_CHK_EN
    logic        w_misaligned;
    logic        r_misalign;

    assign w_misaligned      = |redirect_pc[1:0];
    assign w_redirect_target = redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (redirect_en) begin
            r_misalign <= w_misaligned;
        end
    end

    assign misalign_exc = r_misalign;
`else
    assign w_redirect_target = redirect_pc & c_word_mask;
    assign misalign_exc      = 1'b0;
`endif

    // A full buffer blocks fetch so that at most one word is ever parked.
    assign imem_req  = !rst && (r_state == ST_REQ) && !r_buf_valid;
    assign imem_addr = r_pc & c_word_mask;
    assign w_accept  = imem_req && imem_ready;

    assign id_valid  = r_id_valid;
    assign id_inst   = r_id_inst;
    assign id_pc     = r_id_pc;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_launch_nxt    = r_launch_pc;
        w_pending_nxt   = r_pending;
        w_buf_valid_nxt = r_buf_valid;
        w_buf_inst_nxt  = r_buf_inst;
        w_buf_pc_nxt    = r_buf_pc;
        w_id_valid_nxt  = r_id_valid;
        w_id_inst_nxt   = r_id_inst;
        w_id_pc_nxt     = r_id_pc;
        w_resp_valid    = 1'b0;

        // Tracks the bus-level outstanding request independent of the state,
        // so a redirect out of EXC still knows whether a response is due.
        if (w_accept) begin
            w_pending_nxt = 1'b1;
        end else if (imem_rvalid) begin
            w_pending_nxt = 1'b0;
        end

        case (r_state)
            ST_REQ: begin
                if (w_accept) begin
                    w_pc_nxt     = r_pc + 32'd4;
                    w_launch_nxt = r_pc;
                    w_state_nxt  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    w_resp_valid = 1'b1;
                    w_state_nxt  = ST_REQ;
                end
            end
            ST_KILL: begin
                if (imem_rvalid) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_EXC: begin
                w_state_nxt = ST_EXC;
            end
            default: begin
                w_state_nxt = ST_REQ;
            end
        endcase

        if (redirect_en || flush) begin
            w_id_valid_nxt  = 1'b0;
            w_id_inst_nxt   = c_nop;
            w_buf_valid_nxt = 1'b0;
        end else if (stall) begin
            if (w_resp_valid) begin
                w_buf_valid_nxt = 1'b1;
                w_buf_inst_nxt  = imem_rdata;
                w_buf_pc_nxt    = r_launch_pc;
            end
        end else if (r_buf_valid) begin
            w_id_valid_nxt  = 1'b1;
            w_id_inst_nxt   = r_buf_inst;
            w_id_pc_nxt     = r_buf_pc;
            w_buf_valid_nxt = 1'b0;
        end else if (w_resp_valid) begin
            w_id_valid_nxt = 1'b1;
            w_id_inst_nxt  = imem_rdata;
            w_id_pc_nxt    = r_launch_pc;
        end else begin
            w_id_valid_nxt = 1'b0;
            w_id_inst_nxt  = c_nop;
        end

        if (redirect_en) begin
            w_pc_nxt = w_redirect_target;
            // A response still in flight after this edge must be discarded.
            if (w_accept || (r_pending && !imem_rvalid)) begin
                w_state_nxt = ST_KILL;
            end else begin
                w_state_nxt = ST_REQ;
            end
`ifdef IF_MISALIGN_CHK_EN
            if (w_misaligned) begin
                w_state_nxt = ST_EXC;
                w_id_pc_nxt = redirect_pc;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_REQ;
            r_pc        <= RESET_PC;
            r_launch_pc <= '0;
            r_pending   <= 1'b0;
            r_buf_valid <= 1'b0;
            r_buf_inst  <= c_nop;
            r_buf_pc    <= '0;
            r_id_valid  <= 1'b0;
            r_id_inst   <= c_nop;
            r_id_pc     <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_launch_pc <= w_launch_nxt;
            r_pending   <= w_pending_nxt;
            r_buf_valid <= w_buf_valid_nxt;
            r_buf_inst  <= w_buf_inst_nxt;
            r_buf_pc    <= w_buf_pc_nxt;
            r_id_valid  <= w_id_valid_nxt;
            r_id_inst   <= w_id_inst_nxt;
            r_id_pc     <= w_id_pc_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Brief    : Randomized bench for if_stage: memory model, fetch-order model and
//            an instruction-stream scoreboard. Honours IF_MISALIGN_CHK_EN.
// Revision : 1.0
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] c_reset_pc = 32'h0000_0000;
    localparam logic [31:0] c_nop      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        flush;
    logic        redirect_en;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic [31:0] id_inst;
    logic [31:0] id_pc;
    logic        misalign_exc;

    if_stage #(.RESET_PC(c_reset_pc)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .stall(stall), .flush(flush),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_inst(id_inst), .id_pc(id_pc),
        .misalign_exc(misalign_exc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        sb_q[$];
    logic [31:0] acc_log[$];
    int          total = 0;
    int          bad   = 0;

    // memory model and knobs
    bit          pend;
    bit          pend_live;
    bit          pend_stale;
    logic [31:0] pend_addr;
    int          pend_cnt;
    int          p_ready, p_stall, lat_min, lat_max;
    logic [31:0] model_fetch;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        if (a == 32'h0) return 32'h00A0_0093;
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    function automatic logic [31:0] tgt(input logic [31:0] p);
`ifdef IF_MISALIGN_CHK_EN
        return p;
`else
        return {p[31:2], 2'b00};
`endif
    endfunction

    task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at posedge+1, account at negedge.
    task automatic step(input int smode, input bit rd, input logic [31:0] rpc, input bit fl, input bit r);
        @(posedge clk);
        #1;
        rst         = r;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            pend_cnt--;
            if (pend_cnt <= 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memfn(pend_addr);
                if (pend_live) sb_q.push_back('{pc: pend_addr, inst: memfn(pend_addr)});
                pend       = 1'b0;
                pend_stale = 1'b0;
            end
        end
        imem_ready  = pend ? 1'b0 : ($urandom_range(99) < p_ready);
        stall       = (smode == 2) ? ($urandom_range(99) < p_stall) : (smode == 1);
        redirect_en = rd;
        redirect_pc = rpc;
        flush       = fl;
        @(negedge clk);
        if (rst) begin
            chk(imem_req == 1'b0, "req_in_reset", imem_req, 0);
            model_fetch = c_reset_pc;
            if (pend) begin
                pend_live  = 1'b0;
                pend_stale = 1'b1;
            end
        end else begin
            if (pend && !pend_stale) chk(imem_req == 1'b0, "one_outstanding", imem_req, 0);
            if (imem_req && imem_ready) begin
                chk(imem_addr == model_fetch, "fetch_addr", imem_addr, model_fetch);
                acc_log.push_back(imem_addr);
                pend      = 1'b1;
                pend_addr = imem_addr;
                pend_cnt  = $urandom_range(lat_max, lat_min);
                pend_live = !redirect_en;
                model_fetch = model_fetch + 32'd4;
            end
            if (redirect_en) begin
                pend_live   = 1'b0;
                model_fetch = tgt(redirect_pc);
            end
        end
    endtask

    // n reset cycles, then the first live cycle with reset-value checks.
    task automatic do_reset(input int n);
        repeat (n) step(0, 0, 32'h0, 0, 1);
        step(0, 0, 32'h0, 0, 0);
        chk(id_valid == 1'b0, "rst_id_valid", id_valid, 0);
        chk(id_inst == c_nop, "rst_id_inst", id_inst, c_nop);
        chk(id_pc == 32'h0, "rst_id_pc", id_pc, 0);
        chk(misalign_exc == 1'b0, "rst_misalign", misalign_exc, 0);
        chk(imem_req == 1'b1, "rst_req", imem_req, 1);
    endtask

    // Scoreboard monitor: pops the expected stream whenever decode consumes.
    ent_t        e;
    bit          have_prev, prev_kill, prev_stall, exp_mis;
    logic        pv;
    logic [31:0] pi, pp;

    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
            have_prev = 1'b0;
            exp_mis   = 1'b0;
        end else begin
            if (!id_valid) chk(id_inst == c_nop, "bubble_nop", id_inst, c_nop);
            if (have_prev && prev_kill) begin
                chk(id_valid == 1'b0, "kill_bubble", id_valid, 0);
            end else if (have_prev && prev_stall) begin
                chk(id_valid == pv, "hold_valid", id_valid, pv);
                chk(id_inst == pi, "hold_inst", id_inst, pi);
                chk(id_pc == pp, "hold_pc", id_pc, pp);
            end
            chk(misalign_exc == exp_mis, "misalign", misalign_exc, exp_mis);
            if (exp_mis) chk(imem_req == 1'b0, "exc_no_req", imem_req, 0);
            if (id_valid && !stall) begin
                if (sb_q.size() == 0) begin
                    chk(1'b0, "unexpected_inst", id_pc, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    chk(id_pc == e.pc, "id_pc", id_pc, e.pc);
                    chk(id_inst == e.inst, "id_inst", id_inst, e.inst);
                end
            end
            if (redirect_en || flush) sb_q.delete();
`ifdef IF_MISALIGN_CHK_EN
            if (redirect_en) exp_mis = (redirect_pc[1:0] != 2'b00);
`endif
            pv = id_valid; pi = id_inst; pp = id_pc;
            prev_kill  = redirect_en || flush;
            prev_stall = stall;
            have_prev  = 1'b1;
        end
    end

    initial begin
        logic [31:0] a0;
        logic [31:0] rv;
        bit          saw;
        bit          rd, fl;

        rst = 1'b1; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        stall = 1'b0; flush = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
        pend = 1'b0; pend_live = 1'b0; pend_stale = 1'b0; pend_addr = '0; pend_cnt = 0;
        model_fetch = c_reset_pc;
        p_ready = 100; p_stall = 0; lat_min = 1; lat_max = 1;

        // basic stream and two-cycle latency
        do_reset(2);
        step(0, 0, 32'h0, 0, 0);
        chk(id_valid == 1'b0, "lat_early", id_valid, 0);
        step(0, 0, 32'h0, 0, 0);
        chk(id_valid == 1'b1, "lat_valid", id_valid, 1);
        chk(id_pc == 32'h0, "lat_pc", id_pc, 0);
        repeat (6) step(0, 0, 32'h0, 0, 0);

        // response parked while decode stalls
        do_reset(1);
        step(1, 0, 32'h0, 0, 0);
        repeat (2) begin
            step(1, 0, 32'h0, 0, 0);
            chk(imem_req == 1'b0, "stall_noreq", imem_req, 0);
            chk(id_valid == 1'b0, "stall_idv", id_valid, 0);
        end
        step(0, 0, 32'h0, 0, 0);
        step(0, 0, 32'h0, 0, 0);
        chk(id_valid == 1'b1, "unstall_valid", id_valid, 1);
        chk(id_inst == 32'h00A0_0093, "unstall_inst", id_inst, 32'h00A0_0093);
        chk(id_pc == 32'h0, "unstall_pc", id_pc, 0);
        repeat (4) step(0, 0, 32'h0, 0, 0);

        // redirect while a response is outstanding
        lat_min = 3; lat_max = 3;
        do_reset(1);
        step(0, 1, 32'h0000_0100, 0, 0);
        acc_log.delete();
        step(0, 0, 32'h0, 0, 0);
        chk(imem_req == 1'b0, "kill_noreq", imem_req, 0);
        repeat (8) step(0, 0, 32'h0, 0, 0);
        a0 = (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF;
        chk(a0 == 32'h0000_0100, "redir_addr", a0, 32'h100);

        // reset while a request is outstanding
        do_reset(1);
        step(0, 0, 32'h0, 0, 0);
        do_reset(1);
        repeat (10) step(0, 0, 32'h0, 0, 0);

        // address wrap
        lat_min = 1; lat_max = 1;
        step(0, 1, 32'hFFFF_FFF8, 0, 0);
        acc_log.delete();
        repeat (12) step(0, 0, 32'h0, 0, 0);
        saw = 1'b0;
        for (int i = 0; i + 1 < acc_log.size(); i++)
            if (acc_log[i] == 32'hFFFF_FFFC && acc_log[i+1] == 32'h0) saw = 1'b1;
        chk(saw, "pc_wrap", {31'b0, saw}, 1);

        // misaligned redirect target
        step(0, 1, 32'h0000_0102, 0, 0);
        acc_log.delete();
`ifdef IF_MISALIGN_CHK_EN
        repeat (4) begin
            step(0, 0, 32'h0, 0, 0);
            chk(misalign_exc == 1'b1, "exc_flag", misalign_exc, 1);
            chk(imem_req == 1'b0, "exc_req", imem_req, 0);
        end
        chk(id_pc == 32'h0000_0102, "exc_id_pc", id_pc, 32'h102);
        step(0, 1, 32'h0000_0200, 0, 0);
        acc_log.delete();
        step(0, 0, 32'h0, 0, 0);
        chk(misalign_exc == 1'b0, "exc_clear", misalign_exc, 0);
        repeat (6) step(0, 0, 32'h0, 0, 0);
        a0 = (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF;
        chk(a0 == 32'h0000_0200, "exc_resume", a0, 32'h200);
`else
        step(0, 0, 32'h0, 0, 0);
        chk(misalign_exc == 1'b0, "mis_tied", misalign_exc, 0);
        repeat (6) step(0, 0, 32'h0, 0, 0);
        a0 = (acc_log.size() > 0) ? acc_log[0] : 32'hDEAD_BEEF;
        chk(a0 == 32'h0000_0100, "mis_masked", a0, 32'h100);
`endif

        // randomized traffic
        p_ready = 70; p_stall = 30; lat_min = 1; lat_max = 3;
        for (int i = 0; i < 2500; i++) begin
            rd = ($urandom_range(99) < 4);
            fl = ($urandom_range(99) < 4);
            rv = $urandom;
`ifdef IF_MISALIGN_CHK_EN
            rv[1:0] = 2'b00;
`endif
            step(2, rd, rv, fl, 0);
        end
        repeat (8) step(0, 0, 32'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
